branch_unit: RTL and testbench

BRANCH_UNIT -- requirements
Module: branch_unit

---
 rtl/branch_pkg.sv | 24 ++
 rtl/cond_eval.sv | 35 +++
 rtl/branch_unit.sv | 124 ++++++++++++
 tb/tb_branch_unit.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared types and constants for the branch resolution unit.
package branch_pkg;

  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_B    = 2'b01,
    BR_COND = 2'b10,
    BR_CBZ  = 2'b11
  } br_type_t;

  typedef enum logic [3:0] {
    C_EQ, C_NE, C_HS, C_LO, C_MI, C_PL, C_VS, C_VC,
    C_HI, C_LS, C_GE, C_LT, C_GT, C_LE, C_AL, C_NV
  } cond_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_HOLD  = 2'b01,
    ST_FLUSH = 2'b10
  } state_t;

  localparam int PC_INC = 4;

endpackage

// File: rtl/cond_eval.sv
// Combinational ARM condition-code evaluator against N/Z/V/C flags.
module cond_eval
  import branch_pkg::*;
(
  input  logic [3:0] cond,
  input  logic       n,
  input  logic       z,
  input  logic       v,
  input  logic       c,
  output logic       pass
);

  always_comb begin
    pass = 1'b0;
    case (cond_t'(cond))
      C_EQ: pass = z;
      C_NE: pass = !z;
      C_HS: pass = c;
      C_LO: pass = !c;
      C_MI: pass = n;
      C_PL: pass = !n;
      C_VS: pass = v;
      C_VC: pass = !v;
      C_HI: pass = c && !z;
      C_LS: pass = !c || z;
      C_GE: pass = (n == v);
      C_LT: pass = (n != v);
      C_GT: pass = !z && (n == v);
      C_LE: pass = z || (n != v);
      C_AL: pass = 1'b1;
      C_NV: pass = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_unit.sv
// Branch resolution: decides taken/target for one instruction per handshake,
// holds the result until consumed and raises a one-cycle flush after a taken branch.
module branch_unit
  import branch_pkg::*;
#(
  parameter int ADDR_W = 64,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        br_type,
  input  logic [3:0]        cond,
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] imm,
  input  logic [63:0]       cbz_val,
  input  logic              negative,
  input  logic              zero,
  input  logic              overflow,
  input  logic              carry_out,
  input  logic              fwd_en,
  input  logic              fwd_negative,
  input  logic              fwd_zero,
  input  logic              fwd_overflow,
  input  logic              fwd_carry,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              taken,
  output logic [ADDR_W-1:0] target,
  output logic              flush,
  output logic [CNT_W-1:0]  br_cnt,
  output logic [CNT_W-1:0]  taken_cnt
);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
    return (&val) ? val : val + CNT_W'(1);
  endfunction

  state_t                     state_p1, state_nxt;
  logic                       taken_p1;
  logic [ADDR_W-1:0]          target_p1;
  logic [CNT_W-1:0]           br_cnt_p1, taken_cnt_p1;
  logic                       eff_n, eff_z, eff_v, eff_c;
  logic                       cond_pass, taken_p0, accept;
  logic signed [ADDR_W-1:0]   offset_p0;
  logic [ADDR_W-1:0]          target_p0;

  // Stage p0: resolve the branch from the inputs sampled this edge
  assign eff_n = fwd_en ? fwd_negative : negative;
  assign eff_z = fwd_en ? fwd_zero     : zero;
  assign eff_v = fwd_en ? fwd_overflow : overflow;
  assign eff_c = fwd_en ? fwd_carry    : carry_out;

  cond_eval u_cond_eval (
    .cond (cond),
    .n    (eff_n),
    .z    (eff_z),
    .v    (eff_v),
    .c    (eff_c),
    .pass (cond_pass)
  );

  always_comb begin
    taken_p0 = 1'b0;
    case (br_type_t'(br_type))
      BR_B:    taken_p0 = 1'b1;
      BR_COND: taken_p0 = cond_pass;
      BR_CBZ:  taken_p0 = (cbz_val == '0);
      default: taken_p0 = 1'b0;
    endcase
  end

  assign offset_p0 = $signed(imm) <<< 2;
  assign target_p0 = taken_p0 ? pc + $unsigned(offset_p0) : pc + ADDR_W'(PC_INC);

  // A not-taken result may be replaced in the same cycle it is consumed
  assign in_ready = (state_p1 == ST_IDLE) ||
                    ((state_p1 == ST_HOLD) && out_ready && !taken_p1);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_nxt = state_p1;
    case (state_p1)
      ST_IDLE:  state_nxt = accept ? ST_HOLD : ST_IDLE;
      ST_HOLD: begin
        if (out_ready) begin
          if (taken_p1)    state_nxt = ST_FLUSH;
          else if (accept) state_nxt = ST_HOLD;
          else             state_nxt = ST_IDLE;
        end
      end
      ST_FLUSH: state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Stage p1: registered result, FSM and statistics
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_p1     <= ST_IDLE;
      taken_p1     <= 1'b0;
      target_p1    <= '0;
      br_cnt_p1    <= '0;
      taken_cnt_p1 <= '0;
    end else begin
      state_p1 <= state_nxt;
      if (accept) begin
        taken_p1  <= taken_p0;
        target_p1 <= target_p0;
        if (br_type != 2'b00) br_cnt_p1    <= sat_inc(br_cnt_p1);
        if (taken_p0)         taken_cnt_p1 <= sat_inc(taken_cnt_p1);
      end
    end
  end

  assign out_valid = (state_p1 == ST_HOLD);
  assign flush     = (state_p1 == ST_FLUSH);
  assign taken     = taken_p1;
  assign target    = target_p1;
  assign br_cnt    = br_cnt_p1;
  assign taken_cnt = taken_cnt_p1;

endmodule

// File: tb/tb_branch_unit.sv
// Bench for branch_unit: transaction-level reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_branch_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [1:0]  br_type;
  logic [3:0]  cond;
  logic [63:0] pc, imm, cbz_val;
  logic        negative, zero, overflow, carry_out;
  logic        fwd_en, fwd_negative, fwd_zero, fwd_overflow, fwd_carry;
  logic        out_ready;

  logic        in_ready, out_valid, taken, flush;
  logic [63:0] target;
  logic [15:0] br_cnt, taken_cnt;
  logic        in_ready4, out_valid4, taken4, flush4;
  logic [63:0] target4;
  logic [3:0]  br_cnt4, taken_cnt4;

  always #5 clk = ~clk;

  branch_unit #(.ADDR_W(64), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .br_type(br_type), .cond(cond), .pc(pc), .imm(imm), .cbz_val(cbz_val),
    .negative(negative), .zero(zero), .overflow(overflow), .carry_out(carry_out),
    .fwd_en(fwd_en), .fwd_negative(fwd_negative), .fwd_zero(fwd_zero),
    .fwd_overflow(fwd_overflow), .fwd_carry(fwd_carry),
    .out_valid(out_valid), .out_ready(out_ready), .taken(taken), .target(target),
    .flush(flush), .br_cnt(br_cnt), .taken_cnt(taken_cnt)
  );

  branch_unit #(.ADDR_W(64), .CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready4),
    .br_type(br_type), .cond(cond), .pc(pc), .imm(imm), .cbz_val(cbz_val),
    .negative(negative), .zero(zero), .overflow(overflow), .carry_out(carry_out),
    .fwd_en(fwd_en), .fwd_negative(fwd_negative), .fwd_zero(fwd_zero),
    .fwd_overflow(fwd_overflow), .fwd_carry(fwd_carry),
    .out_valid(out_valid4), .out_ready(out_ready), .taken(taken4), .target(target4),
    .flush(flush4), .br_cnt(br_cnt4), .taken_cnt(taken_cnt4)
  );

  int total  = 0;
  int passed = 0;
  bit started = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: one result slot, a pending-flush marker and four counters
  bit          occ, m_taken, m_flush;
  logic [63:0] m_target;
  int          br16, tk16, br4, tk4;
  bit          acc, leave, m_tk, en, ez, ev, ec;

  function automatic bit ref_cond(input logic [3:0] c, input bit n, z, v, cy);
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  function automatic bit ref_ready();
    return !m_flush && (!occ || (out_ready && !m_taken));
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      occ = 0; m_taken = 0; m_flush = 0; m_target = '0;
      br16 = 0; tk16 = 0; br4 = 0; tk4 = 0;
    end else begin
      acc   = in_valid && ref_ready();
      leave = occ && out_ready;
      m_flush = leave && m_taken;
      if (leave) occ = 0;
      if (acc) begin
        en = fwd_en ? fwd_negative : negative;
        ez = fwd_en ? fwd_zero     : zero;
        ev = fwd_en ? fwd_overflow : overflow;
        ec = fwd_en ? fwd_carry    : carry_out;
        case (br_type)
          2'b01:   m_tk = 1;
          2'b10:   m_tk = ref_cond(cond, en, ez, ev, ec);
          2'b11:   m_tk = (cbz_val == 64'd0);
          default: m_tk = 0;
        endcase
        occ = 1;
        m_taken  = m_tk;
        m_target = m_tk ? pc + imm * 64'd4 : pc + 64'd4;
        if (br_type != 2'b00) begin
          if (br16 < 65535) br16++;
          if (br4 < 15) br4++;
        end
        if (m_tk) begin
          if (tk16 < 65535) tk16++;
          if (tk4 < 15) tk4++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("out_valid", out_valid, occ);
      check("flush", flush, m_flush);
      check("in_ready", in_ready, ref_ready());
      if (occ) begin
        check("taken", taken, m_taken);
        check("target", target, m_target);
      end
      check("br_cnt", br_cnt, br16);
      check("taken_cnt", taken_cnt, tk16);
      check("out_valid_w4", out_valid4, occ);
      check("br_cnt_w4", br_cnt4, br4);
      check("taken_cnt_w4", taken_cnt4, tk4);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] bt, input logic [3:0] cc, input logic [63:0] p,
                      input logic [63:0] im, input logic [63:0] cz, input logic [3:0] flg,
                      input bit fe, input logic [3:0] fflg);
    int k;
    k = 0;
    #1;
    while (!in_ready && k < 20) begin
      @(posedge clk);
      #2;
      k++;
    end
    if (!in_ready) check("send_wait", in_ready, 1'b1);
    br_type = bt; cond = cc; pc = p; imm = im; cbz_val = cz;
    {negative, zero, overflow, carry_out} = flg;
    fwd_en = fe;
    {fwd_negative, fwd_zero, fwd_overflow, fwd_carry} = fflg;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    logic [31:0] r;
    reset = 1'b0; in_valid = 1'b0; br_type = '0; cond = '0;
    pc = '0; imm = '0; cbz_val = '0;
    negative = 0; zero = 0; overflow = 0; carry_out = 0;
    fwd_en = 0; fwd_negative = 0; fwd_zero = 0; fwd_overflow = 0; fwd_carry = 0;
    out_ready = 1'b1;

    tick();
    started = 1'b1;
    tick();
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_taken", taken, 1'b0);
    check("rst_target", target, 64'h0);
    check("rst_flush", flush, 1'b0);
    check("rst_br_cnt", br_cnt, 16'd0);
    check("rst_taken_cnt", taken_cnt, 16'd0);
    reset = 1'b1;

    // B.EQ with stored Z=1
    send(2'b10, 4'h0, 64'h100, 64'd4, 64'd1, 4'b0100, 1'b0, 4'b0000);
    check("eq_valid", out_valid, 1'b1);
    check("eq_taken", taken, 1'b1);
    check("eq_target", target, 64'h110);
    tick();
    check("eq_flush", flush, 1'b1);
    check("eq_flush_in_ready", in_ready, 1'b0);
    tick();
    check("eq_flush_done", flush, 1'b0);

    // B.GE: forwarded N=1,V=0 override stored N=1,V=1
    send(2'b10, 4'hA, 64'h200, 64'd8, 64'd1, 4'b1010, 1'b1, 4'b1000);
    check("ge_fwd_taken", taken, 1'b0);
    check("ge_fwd_target", target, 64'h204);
    tick();

    send(2'b11, 4'h0, 64'h40, 64'hFFFF_FFFF_FFFF_FFFE, 64'd0, 4'b0000, 1'b0, 4'b0000);
    check("cbz0_taken", taken, 1'b1);
    check("cbz0_target", target, 64'h38);
    tick(); tick();
    send(2'b11, 4'h0, 64'h40, 64'hFFFF_FFFF_FFFF_FFFE, 64'd5, 4'b0000, 1'b0, 4'b0000);
    check("cbz5_taken", taken, 1'b0);
    check("cbz5_target", target, 64'h44);
    tick();

    // Stall the consumer for three cycles, then stream back-to-back
    out_ready = 1'b0;
    send(2'b00, 4'h0, 64'h500, 64'd3, 64'd1, 4'b0000, 1'b0, 4'b0000);
    check("stall_target0", target, 64'h504);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_valid", out_valid, 1'b1);
      check("stall_taken", taken, 1'b0);
      check("stall_target", target, 64'h504);
      check("stall_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      br_type = 2'b00; pc = 64'h600 + 64'(i * 16); in_valid = 1'b1;
      tick();
      check("b2b_valid", out_valid, 1'b1);
      check("b2b_target", target, 64'h604 + 64'(i * 16));
      check("b2b_in_ready", in_ready, 1'b1);
    end
    in_valid = 1'b0;
    tick();

    for (int i = 0; i < 20; i++)
      send(2'b01, 4'h0, 64'h1000 + 64'(i * 4), 64'd1, 64'd1, 4'b0000, 1'b0, 4'b0000);
    check("sat_br_cnt_w4", br_cnt4, 4'd15);
    check("sat_taken_cnt_w4", taken_cnt4, 4'd15);
    check("br_cnt_24", br_cnt, 16'd24);
    check("taken_cnt_22", taken_cnt, 16'd22);
    tick(); tick();

    // Reset while a taken result is held
    out_ready = 1'b0;
    send(2'b01, 4'h0, 64'h2000, 64'd2, 64'd1, 4'b0000, 1'b0, 4'b0000);
    check("hold_valid", out_valid, 1'b1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    out_ready = 1'b1;
    check("hrst_valid", out_valid, 1'b0);
    check("hrst_br_cnt", br_cnt, 16'd0);
    check("hrst_taken_cnt", taken_cnt, 16'd0);
    check("hrst_taken", taken, 1'b0);
    check("hrst_target", target, 64'h0);
    tick();
    check("hrst_no_flush", flush, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      r = $urandom;
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 3) != 0);
      reset     = ($urandom_range(0, 149) != 0);
      br_type   = 2'($urandom);
      cond      = 4'($urandom);
      pc        = {$urandom, $urandom};
      imm       = r[0] ? {{32{r[31]}}, r} : {{52{r[31]}}, r[11:0]};
      cbz_val   = ($urandom_range(0, 2) == 0) ? 64'd0 : {$urandom, $urandom};
      {negative, zero, overflow, carry_out} = 4'($urandom);
      fwd_en    = 1'($urandom);
      {fwd_negative, fwd_zero, fwd_overflow, fwd_carry} = 4'($urandom);
      tick();
    end
    in_valid = 1'b0;
    reset = 1'b1;
    out_ready = 1'b1;
    repeat (3) tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
